// File: rtl/pipe_reg.sv
// Pipeline register stage with valid/ready handshake, synchronous flush and an
// optional two-entry skid buffer that keeps in_ready free of out_ready.
module pipe_reg #(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter bit               SKID        = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       level
);

    if (SKID) begin : g_skid
        // Encoding doubles as the level output.
        typedef enum logic [1:0] {
            StEmpty = 2'd0,
            StFull  = 2'd1,
            StSkid  = 2'd2
        } state_e;

        state_e           state_q, state_d;
        logic [WIDTH-1:0] out_data_q, out_data_d;
        logic [WIDTH-1:0] skid_q, skid_d;
        logic             in_ready_q, in_ready_d;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q    <= StEmpty;
                out_data_q <= RESET_VALUE;
                skid_q     <= RESET_VALUE;
                in_ready_q <= 1'b1;
            end else begin
                state_q    <= state_d;
                out_data_q <= out_data_d;
                skid_q     <= skid_d;
                in_ready_q <= in_ready_d;
            end
        end

        always_comb begin
            state_d    = state_q;
            out_data_d = out_data_q;
            skid_d     = skid_q;
            if (flush) begin
                state_d = StEmpty;
            end else begin
                unique case (state_q)
                    StEmpty: begin
                        if (in_valid) begin
                            out_data_d = in_data;
                            state_d    = StFull;
                        end
                    end
                    StFull: begin
                        if (out_ready && in_valid) begin
                            out_data_d = in_data;
                        end else if (out_ready) begin
                            state_d = StEmpty;
                        end else if (in_valid) begin
                            skid_d  = in_data;
                            state_d = StSkid;
                        end
                    end
                    StSkid: begin
                        if (out_ready) begin
                            out_data_d = skid_q;
                            state_d    = StFull;
                        end
                    end
                    default: state_d = StEmpty;
                endcase
            end
            // Registered so in_ready never sees out_ready combinationally.
            in_ready_d = (state_d != StSkid);
        end

        always_comb begin
            out_valid = (state_q != StEmpty);
            level     = state_q;
            in_ready  = in_ready_q;
            out_data  = out_data_q;
        end
    end else begin : g_plain
        logic             out_valid_q, out_valid_d;
        logic [WIDTH-1:0] out_data_q, out_data_d;
        logic             up_xfer;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                out_valid_q <= 1'b0;
                out_data_q  <= RESET_VALUE;
            end else begin
                out_valid_q <= out_valid_d;
                out_data_q  <= out_data_d;
            end
        end

        always_comb begin
            in_ready    = !out_valid_q || out_ready;
            up_xfer     = in_valid && in_ready;
            out_valid_d = out_valid_q;
            out_data_d  = out_data_q;
            if (flush) begin
                out_valid_d = 1'b0;
            end else if (up_xfer) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data;
            end else if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
        end

        always_comb begin
            out_valid = out_valid_q;
            out_data  = out_data_q;
            level     = {1'b0, out_valid_q};
        end
    end

endmodule

// File: tb/tb_pipe_reg.sv
// Bench for pipe_reg: a skid instance (32 bit) and a plain instance (8 bit), each
// compared against a queue model of the stage, plus directed vector tables.
module tb_pipe_reg;

    localparam logic [31:0] RV1 = 32'hDEAD_BEEF;
    localparam logic [7:0]  RV0 = 8'hA5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;

    logic [31:0] d1 = '0;
    logic        iv1 = 1'b0, ordy1 = 1'b0;
    logic        ir1, ov1;
    logic [31:0] od1;
    logic [1:0]  lvl1;

    logic [7:0]  d0 = '0;
    logic        iv0 = 1'b0, ordy0 = 1'b0;
    logic        ir0, ov0;
    logic [7:0]  od0;
    logic [1:0]  lvl0;

    int total = 0;
    int bad   = 0;

    logic [31:0] q1[$];
    logic [7:0]  q0[$];

    always #5 clk = ~clk;

    pipe_reg #(.WIDTH(32), .RESET_VALUE(RV1), .SKID(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_data(d1), .in_valid(iv1), .in_ready(ir1),
        .out_data(od1), .out_valid(ov1), .out_ready(ordy1), .level(lvl1)
    );

    pipe_reg #(.WIDTH(8), .RESET_VALUE(RV0), .SKID(1'b0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_data(d0), .in_valid(iv0), .in_ready(ir0),
        .out_data(od0), .out_valid(ov0), .out_ready(ordy0), .level(lvl0)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_check();
        chk("skid out_valid", {31'd0, ov1}, {31'd0, q1.size() != 0});
        chk("skid level", {30'd0, lvl1}, q1.size());
        chk("skid in_ready", {31'd0, ir1}, {31'd0, q1.size() < 2});
        if (q1.size() != 0) chk("skid out_data", od1, q1[0]);
        chk("plain out_valid", {31'd0, ov0}, {31'd0, q0.size() != 0});
        chk("plain level", {30'd0, lvl0}, q0.size());
        chk("plain in_ready", {31'd0, ir0}, {31'd0, (q0.size() == 0) || ordy0});
        if (q0.size() != 0) chk("plain out_data", {24'd0, od0}, {24'd0, q0[0]});
    endtask

    // Applies the transfer rules to the beats held just before the edge.
    task automatic model_update();
        bit pop, push;
        pop  = (q1.size() != 0) && ordy1;
        push = iv1 && (q1.size() < 2);
        if (flush) q1.delete();
        else begin
            if (pop) void'(q1.pop_front());
            if (push) q1.push_back(d1);
        end
        pop  = (q0.size() != 0) && ordy0;
        push = iv0 && ((q0.size() == 0) || ordy0);
        if (flush) q0.delete();
        else begin
            if (pop) void'(q0.pop_front());
            if (push) q0.push_back(d0);
        end
    endtask

    task automatic step();
        #1;
        model_check();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, " ov"}, {31'd0, ov1}, 32'd0);
        chk({nm, " lvl"}, {30'd0, lvl1}, 32'd0);
        chk({nm, " ir"}, {31'd0, ir1}, 32'd1);
        chk({nm, " od"}, od1, RV1);
        chk({nm, " plain ov"}, {31'd0, ov0}, 32'd0);
        chk({nm, " plain od"}, {24'd0, od0}, {24'd0, RV0});
    endtask

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        eov;
        logic [1:0]  elvl;
        logic        eir;
        logic [31:0] eod;
    } vec_t;

    vec_t tbl[22];

    initial begin
        // Expected outputs are those visible while the row's inputs are applied.
        tbl[0]  = '{1'b0, 1'b1, 32'h11, 1'b1, 1'b0, 2'd0, 1'b1, 32'h0};
        tbl[1]  = '{1'b0, 1'b1, 32'h22, 1'b1, 1'b1, 2'd1, 1'b1, 32'h11};
        tbl[2]  = '{1'b0, 1'b1, 32'h33, 1'b1, 1'b1, 2'd1, 1'b1, 32'h22};
        tbl[3]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 2'd1, 1'b1, 32'h33};
        tbl[4]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 2'd0, 1'b1, 32'h0};
        tbl[5]  = '{1'b0, 1'b1, 32'hA,  1'b0, 1'b0, 2'd0, 1'b1, 32'h0};
        tbl[6]  = '{1'b0, 1'b1, 32'hB,  1'b0, 1'b1, 2'd1, 1'b1, 32'hA};
        tbl[7]  = '{1'b0, 1'b1, 32'hC,  1'b0, 1'b1, 2'd2, 1'b0, 32'hA};
        tbl[8]  = '{1'b0, 1'b1, 32'hC,  1'b0, 1'b1, 2'd2, 1'b0, 32'hA};
        tbl[9]  = '{1'b0, 1'b1, 32'hC,  1'b1, 1'b1, 2'd2, 1'b0, 32'hA};
        tbl[10] = '{1'b0, 1'b1, 32'hC,  1'b1, 1'b1, 2'd1, 1'b1, 32'hB};
        tbl[11] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 2'd1, 1'b1, 32'hC};
        tbl[12] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 2'd0, 1'b1, 32'h0};
        tbl[13] = '{1'b0, 1'b1, 32'h5,  1'b0, 1'b0, 2'd0, 1'b1, 32'h0};
        tbl[14] = '{1'b0, 1'b1, 32'h6,  1'b0, 1'b1, 2'd1, 1'b1, 32'h5};
        tbl[15] = '{1'b1, 1'b1, 32'h7,  1'b0, 1'b1, 2'd2, 1'b0, 32'h5};
        tbl[16] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 2'd0, 1'b1, 32'h0};
        tbl[17] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 2'd0, 1'b1, 32'h0};
        tbl[18] = '{1'b0, 1'b1, 32'h8,  1'b0, 1'b0, 2'd0, 1'b1, 32'h0};
        tbl[19] = '{1'b0, 1'b1, 32'h9,  1'b0, 1'b1, 2'd1, 1'b1, 32'h8};
        tbl[20] = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 2'd2, 1'b0, 32'h8};
        tbl[21] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 2'd0, 1'b1, 32'h0};

        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("reset initial");
        rst = 1'b0;
        q1.delete();
        q0.delete();

        // Directed skid-mode sequences; plain instance idles meanwhile.
        for (int i = 0; i < 22; i++) begin
            flush = tbl[i].fl;
            iv1   = tbl[i].iv;
            d1    = tbl[i].d;
            ordy1 = tbl[i].ordy;
            iv0   = 1'b0;
            ordy0 = 1'b0;
            #1;
            chk($sformatf("vec%0d ov", i), {31'd0, ov1}, {31'd0, tbl[i].eov});
            chk($sformatf("vec%0d lvl", i), {30'd0, lvl1}, {30'd0, tbl[i].elvl});
            chk($sformatf("vec%0d ir", i), {31'd0, ir1}, {31'd0, tbl[i].eir});
            if (tbl[i].eov) chk($sformatf("vec%0d od", i), od1, tbl[i].eod);
            step();
        end
        flush = 1'b0;

        // Plain mode: full and stalled, then ready rises with a new beat.
        iv1 = 1'b0; ordy1 = 1'b1;
        iv0 = 1'b1; d0 = 8'h5A; ordy0 = 1'b0;
        step();
        d0 = 8'h99;
        #1 chk("plain stalled in_ready", {31'd0, ir0}, 32'd0);
        step();
        d0 = 8'h3C; ordy0 = 1'b1;
        #1 chk("plain comb in_ready", {31'd0, ir0}, 32'd1);
        step();
        iv0 = 1'b0;
        #1;
        chk("plain 3C ov", {31'd0, ov0}, 32'd1);
        chk("plain 3C od", {24'd0, od0}, 32'h3C);
        step();
        step();

        // Randomised traffic on both instances.
        for (int n = 0; n < 3000; n++) begin
            iv1   = ($urandom_range(0, 3) != 0);
            d1    = $urandom;
            ordy1 = $urandom_range(0, 1) == 1;
            iv0   = ($urandom_range(0, 3) != 0);
            d0    = 8'($urandom);
            ordy0 = $urandom_range(0, 1) == 1;
            flush = ($urandom_range(0, 31) == 0);
            step();
        end
        flush = 1'b0;

        // Async reset while both skid entries are occupied.
        iv1 = 1'b1; ordy1 = 1'b0; iv0 = 1'b1; ordy0 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            d1 = 32'h100 + k;
            d0 = 8'h10 + 8'(k);
            step();
        end
        #1 chk("pre-reset level", {30'd0, lvl1}, 32'd2);
        #1 rst = 1'b1;
        #1 chk_reset_outputs("reset mid-stream");
        q1.delete();
        q0.delete();
        @(negedge clk);
        rst = 1'b0;
        iv1 = 1'b1; d1 = 32'h77; ordy1 = 1'b1;
        iv0 = 1'b1; d0 = 8'h77; ordy0 = 1'b1;
        step();
        iv1 = 1'b0; iv0 = 1'b0;
        #1;
        chk("post-reset beat ov", {31'd0, ov1}, 32'd1);
        chk("post-reset beat od", od1, 32'h77);
        step();
        #1 chk("post-reset beat alone", {31'd0, ov1}, 32'd0);
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
